// File: rtl/tf_responder_pkg.sv
// tf_responder_pkg: function IDs, status codes, arity table and FSM states for the call responder
package tf_responder_pkg;
  localparam logic [1:0] FN_SUM = 2'd0;
  localparam logic [1:0] FN_DOUBLE = 2'd1;
  localparam logic [1:0] FN_NO_ARGS = 2'd2;
  localparam logic [1:0] FN_UNDEF = 2'd3;
  localparam logic [1:0] ST_OK = 2'd0;
  localparam logic [1:0] ST_ARITY = 2'd1;
  localparam logic [1:0] ST_NOFUNC = 2'd2;
  typedef enum logic [1:0] {IDLE, ARGS, EXEC, RESP} state_t;
  function automatic logic [1:0] arity(input logic [1:0] f);
    return f == FN_SUM ? 2'd2 : f == FN_DOUBLE ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/tf_responder_if.sv
// tf_responder_if: request beats in, one response per call out
interface tf_responder_if #(parameter int W = 8);
  logic req_valid;
  logic req_ready;
  logic req_hdr;
  logic [1:0] req_func;
  logic [1:0] req_argc;
  logic [W-1:0] req_arg;
  logic resp_valid;
  logic resp_ready;
  logic [W-1:0] resp_result;
  logic [1:0] resp_status;
  modport master (
    output req_valid, req_hdr, req_func, req_argc, req_arg, resp_ready,
    input req_ready, resp_valid, resp_result, resp_status
  );
  modport slave (
    input req_valid, req_hdr, req_func, req_argc, req_arg, resp_ready,
    output req_ready, resp_valid, resp_result, resp_status
  );
endinterface

// File: rtl/tf_responder_alu.sv
// tf_responder_alu: evaluates SUM/DOUBLE/NO_ARGS; TF_RESPONDER_SATURATE_EN makes SUM saturate
module tf_responder_alu
  import tf_responder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   func,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  output logic [W-1:0] result
);
  logic [W-1:0] sum_r;
`ifdef TF_RESPONDER_SATURATE_EN
  logic [W:0] sum;
  assign sum = {1'b0, a0} + {1'b0, a1};
  assign sum_r = sum[W] ? '1 : sum[W-1:0];
`else
  assign sum_r = a0 + a1;
`endif
  // DOUBLE keeps only the low nibble of 2*a0, zero-extended
  always_comb begin
    result = func == FN_SUM ? sum_r :
             func == FN_DOUBLE ? (a0 << 1) & W'(15) :
             func == FN_NO_ARGS ? W'(1) : '0;
  end
endmodule

// File: rtl/tf_responder.sv
// tf_responder: call-channel callee (header + args in, result + status out); TF_RESPONDER_SATURATE_EN selects saturating SUM
module tf_responder
  import tf_responder_pkg::*;
#(
  parameter int W = 8,
  parameter int MAX_ARGC = 3
) (
  input logic clk,
  input logic rst_n,
  tf_responder_if.slave bus
);
  localparam int CW = $clog2(MAX_ARGC + 1);
  state_t state;
  logic [1:0] func;
  logic [CW-1:0] argc;
  logic [CW-1:0] cnt;
  logic [W-1:0] a0;
  logic [W-1:0] a1;
  logic [W-1:0] alu_result;
  logic [1:0] status;
  logic fire;
  assign bus.req_ready = rst_n && (state == IDLE || state == ARGS);
  assign fire = bus.req_valid && bus.req_ready;
  assign status = func == FN_UNDEF ? ST_NOFUNC :
                  argc != CW'(arity(func)) ? ST_ARITY : ST_OK;
  tf_responder_alu #(.W(W)) u_alu (
    .func(func),
    .a0(a0),
    .a1(a1),
    .result(alu_result)
  );
  // call FSM: collect header and args, evaluate once, hold response until accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      func <= '0;
      argc <= '0;
      cnt <= '0;
      a0 <= '0;
      a1 <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_status <= '0;
    end else begin
      case (state)
        IDLE: if (fire && bus.req_hdr) begin
          func <= bus.req_func;
          argc <= bus.req_argc;
          cnt <= '0;
          state <= bus.req_argc == '0 ? EXEC : ARGS;
        end
        ARGS: if (fire) begin
          if (cnt == CW'(0)) a0 <= bus.req_arg;
          if (cnt == CW'(1)) a1 <= bus.req_arg;
          cnt <= cnt + CW'(1);
          if (cnt + CW'(1) == argc) state <= EXEC;
        end
        EXEC: begin
          bus.resp_result <= status == ST_OK ? alu_result : '0;
          bus.resp_status <= status;
          bus.resp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tf_responder.sv
// tb_tf_responder: directed calls with a scoreboard queue checked by an independent response monitor
module tb_tf_responder;
  typedef struct {
    logic [7:0] r;
    logic [1:0] s;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  tf_responder_if #(.W(8)) bus ();
  tf_responder #(.W(8), .MAX_ARGC(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction
  // monitor: every response about to be accepted is compared with the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got result %0d status %0d, expected no response", bus.resp_result, bus.resp_status);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_result", int'(bus.resp_result), int'(e.r));
        chk("resp_status", int'(bus.resp_status), int'(e.s));
      end
    end
  end
  task automatic beat(input logic h, input logic [1:0] f, input logic [1:0] c, input logic [7:0] a);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_hdr = h;
    bus.req_func = f;
    bus.req_argc = c;
    bus.req_arg = a;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: req_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic call(input logic [1:0] f, input logic [1:0] c, input logic [7:0] x0, input logic [7:0] x1,
                      input logic [7:0] x2, input logic [7:0] r, input logic [1:0] s, input bit lat);
    logic [7:0] xs[3];
    xs[0] = x0;
    xs[1] = x1;
    xs[2] = x2;
    exp_q.push_back('{r: r, s: s});
    beat(1'b1, f, c, 8'd0);
    for (int i = 0; i < int'(c); i++) beat(1'b0, 2'd0, 2'd0, xs[i]);
    if (lat) begin
      @(negedge clk);
      chk("lat_exec_valid", int'(bus.resp_valid), 0);
      chk("lat_exec_ready", int'(bus.req_ready), 0);
      @(negedge clk);
      chk("lat_resp_valid", int'(bus.resp_valid), 1);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_hdr = 1'b0;
    bus.req_func = 2'd0;
    bus.req_argc = 2'd0;
    bus.req_arg = 8'd0;
    bus.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_resp_result", int'(bus.resp_result), 0);
    chk("rst_resp_status", int'(bus.resp_status), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", int'(bus.req_ready), 1);
    call(2'd0, 2'd2, 8'd1, 8'd2, 8'd0, 8'd3, 2'd0, 1'b1);
`ifdef TF_RESPONDER_SATURATE_EN
    call(2'd0, 2'd2, 8'd200, 8'd100, 8'd0, 8'd255, 2'd0, 1'b0);
`else
    call(2'd0, 2'd2, 8'd200, 8'd100, 8'd0, 8'd44, 2'd0, 1'b0);
`endif
    call(2'd1, 2'd1, 8'd2, 8'd0, 8'd0, 8'd4, 2'd0, 1'b0);
    call(2'd1, 2'd1, 8'd9, 8'd0, 8'd0, 8'd2, 2'd0, 1'b0);
    call(2'd2, 2'd0, 8'd0, 8'd0, 8'd0, 8'd1, 2'd0, 1'b1);
    call(2'd0, 2'd1, 8'd1, 8'd0, 8'd0, 8'd0, 2'd1, 1'b0);
    call(2'd0, 2'd3, 8'd1, 8'd2, 8'd3, 8'd0, 2'd1, 1'b1);
    call(2'd2, 2'd0, 8'd0, 8'd0, 8'd0, 8'd1, 2'd0, 1'b0);
    call(2'd3, 2'd1, 8'd1, 8'd0, 8'd0, 8'd0, 2'd2, 1'b0);
    beat(1'b0, 2'd0, 2'd0, 8'd77);
    repeat (3) @(negedge clk);
    chk("idle_arg_no_resp", int'(bus.resp_valid), 0);
    bus.resp_ready = 1'b0;
    call(2'd0, 2'd2, 8'd5, 8'd6, 8'd0, 8'd11, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(bus.resp_valid), 1);
      chk("bp_result", int'(bus.resp_result), 11);
      chk("bp_req_ready", int'(bus.req_ready), 0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_released", int'(bus.resp_valid), 0);
    beat(1'b1, 2'd0, 2'd2, 8'd0);
    beat(1'b0, 2'd0, 2'd0, 8'd40);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", int'(bus.req_ready), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", int'(bus.resp_valid), 0);
    end
    call(2'd0, 2'd2, 8'd10, 8'd20, 8'd0, 8'd30, 2'd0, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tf_responder.md
Name: tf_responder

Overview:
- Callee side of the task/function-call channel: receives call requests (header plus argument beats) from a call initiator.
- Checks the function ID and argument count (arity) for each call.
- Evaluates the built-in function and returns one response per call: result plus status.
- Sits behind the call sequencer; implements functions `sum` (2 args), `double` (1 arg) and `no_args` (0 args).

Parameters:
- W, 8: argument and result width.
- MAX_ARGC, 3: largest argument count the header can carry; `req_argc` width is 2.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request beat valid.
- `req_ready` out 1: responder can accept a beat.
- `req_hdr` in 1: 1 = header beat, 0 = argument beat.
- `req_func` in 2: function ID, sampled on header beats only.
- `req_argc` in 2: number of argument beats that follow the header.
- `req_arg` in W: argument value, sampled on argument beats.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: initiator accepts the response.
- `resp_result` out W: function result; 0 when status is not OK.
- `resp_status` out 2: 0 OK, 1 ARITY, 2 NOFUNC.

Behaviour:
- Reset (`rst_n` low at a rising edge):
  - State → IDLE; `resp_valid`=0, `resp_result`=0, `resp_status`=0; argument counter and argument registers cleared.
  - `req_ready`=0 while `rst_n` is low.
  - Reset mid-call discards the call; no response is ever produced for it.
- Handshakes: a beat transfers when `req_valid` and `req_ready` are both high at an edge; a response transfers when `resp_valid` and `resp_ready` are both high.
- Function table (ID: name, arity, result):
  - 0: SUM, arity 2, (a0+a1) mod 2^W.
  - 1: DOUBLE, arity 1, {zeros, (a0[3:0]*2)[3:0]}, i.e. the 4-bit result is truncated then zero-extended.
  - 2: NO_ARGS, arity 0, result 1.
  - 3: undefined → NOFUNC.
- State machine (IDLE, ARGS, EXEC, RESP):
  - IDLE: `req_ready`=1.
    - Header accepted: latch `req_func` and `req_argc`. Go to EXEC if `req_argc`==0, else ARGS.
    - Argument beat accepted in IDLE: silently discarded.
  - ARGS: `req_ready`=1. Each accepted beat (`req_hdr` ignored) is stored at index `cnt` when `cnt`<2 and discarded otherwise; `cnt` increments. When `cnt` reaches `req_argc`, go to EXEC.
  - EXEC: `req_ready`=0, one cycle.
    - Status priority: NOFUNC first, then ARITY (`req_argc` ≠ table arity), else OK.
    - Register `resp_result` and `resp_status`; set `resp_valid`=1; go to RESP.
  - RESP: `req_ready`=0.
    - Hold `resp_result`, `resp_status` and `resp_valid` stable until handshake.
    - On handshake: `resp_valid`=0, go to IDLE.
- Wrong-arity calls still drain exactly `req_argc` argument beats before responding.
- Latency: `resp_valid` rises two edges after the edge accepting the final beat of the call (the header when argc=0). Zero-wait minimum throughput is one call per argc+3 cycles.
- Backpressure: `resp_ready` low holds the block in RESP indefinitely; no new beats are accepted meanwhile.

Optional Feature:
- Macro: `TF_RESPONDER_SATURATE_EN`.
- Defined: SUM saturates, returning 2^W−1 whenever a0+a1 > 2^W−1.
- Undefined: SUM wraps modulo 2^W.
- DOUBLE is unaffected either way.

Decomposition:
- Package `tf_responder_pkg`:
  - Function ID constants: FN_SUM, FN_DOUBLE, FN_NO_ARGS.
  - Status codes: ST_OK, ST_ARITY, ST_NOFUNC.
  - Arity lookup function.
  - State enum.
- Sub-module `tf_responder_alu`: combinational function evaluation from func, a0 and a1 to result, including the saturate option. The FSM, counter and handshakes stay in `tf_responder`.

Test Plan:
- SUM: header(func 0, argc 2), args 1, 2 → result 3, status OK, `resp_valid` two edges after the arg-2 beat.
- SUM overflow: args 200, 100 → result 44 wrap. With `TF_RESPONDER_SATURATE_EN` defined → 255.
- DOUBLE and NO_ARGS:
  - header(1, 1), arg 2 → result 4, OK.
  - arg 9 → result 2 (18 truncated to 4 bits).
  - header(2, 0) → result 1, OK; `resp_valid` two edges after the header.
- Arity errors:
  - header(0, 1), arg 1 → ARITY, result 0.
  - header(0, 3), args 1, 2, 3 → exactly 3 beats drained, then ARITY.
  - Next call header(2, 0) → OK result 1.
- NOFUNC: header(3, 1), arg 1 → NOFUNC, result 0. An argument beat sent while idle is accepted with no response produced.
- Backpressure and reset:
  - Hold `resp_ready`=0 for 5 cycles → response stable, `req_ready`=0.
  - Drive `rst_n`=0 mid-ARGS → no response; `resp_valid` stays 0; the next call completes normally.
